// File: rtl/dcache_arbiter_pkg.sv
// Shared definitions for the dcache arbiter: owner-state encodings, starve
// counter sizing and the default forced-grant threshold.
// Optional feature macro used by the arbiter files: ARB_AGING_EN.
`ifndef DATAPATH_W
`define DATAPATH_W 8
`endif

package dcache_arbiter_pkg;

    // Owner of the cache port for the current cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_SPI  = 2'b01,
        OWN_PROC = 2'b10,
        OWN_DISP = 2'b11
    } owner_e;

    localparam int unsigned STARVE_W         = 4;
    localparam int unsigned STARVE_LIMIT_DEF = 8;

endpackage

// File: rtl/dcache_arbiter_age.sv
// Display starvation tracker for the dcache arbiter (built only when
// ARB_AGING_EN is defined).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   disp_req        display request
//   disp_gnt        display granted this cycle
//   starve_force_c  display must win the next arbitration (combinational)
module dcache_arb_age
    import dcache_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic disp_req,
    input  logic disp_gnt,
    output logic starve_force_c
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] cnt;

    // Count waiting cycles, saturate at the limit, clear once served or idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!disp_req || disp_gnt) begin
            cnt <= '0;
        end else if (cnt != LIMIT) begin
            cnt <= cnt + STARVE_W'(1);
        end
    end

    // Masked by disp_gnt so the saturated count cannot re-force DISP in the
    // very cycle it is finally being served.
    assign starve_force_c = (cnt == LIMIT) && disp_req && !disp_gnt;

endmodule

// File: rtl/dcache_arbiter.sv
// Three-way arbiter for the single dcache port: SPI loader, processor and
// seven-segment display reader. Owner is a registered FSM decided from the
// requests at the end of each cycle; grants are owner AND live request.
// Optional feature: ARB_AGING_EN enables display starvation aging.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   spi_req/we/lock/addr/wdata    SPI loader access (lock holds a burst)
//   proc_req/we/addr/wdata        processor access
//   disp_req/addr                 display read-only access
//   spi_gnt/proc_gnt/disp_gnt     access performed this cycle
//   rdata                         mem_rdata in a granted cycle, else 0
//   mem_wen/addr/wdata, mem_rdata cache port (asynchronous read)
//   busy                          any grant high
`ifndef DATAPATH_W
`define DATAPATH_W 8
`endif

module dcache_arbiter
    import dcache_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned DATA_W       = `DATAPATH_W,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_req,
    input  logic              spi_we,
    input  logic              spi_lock,
    input  logic [ADDR_W-1:0] spi_addr,
    input  logic [DATA_W-1:0] spi_wdata,
    input  logic              proc_req,
    input  logic              proc_we,
    input  logic [ADDR_W-1:0] proc_addr,
    input  logic [DATA_W-1:0] proc_wdata,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              spi_gnt,
    output logic              proc_gnt,
    output logic              disp_gnt,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    // Reject out-of-range thresholds at elaboration.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("dcache_arbiter: STARVE_LIMIT must be in 1..15");
    end

    owner_e owner_q;
    owner_e owner_d;
    logic   age_force_c;

    // A grant needs both ownership and a request still present this cycle.
    assign spi_gnt  = (owner_q == OWN_SPI)  && spi_req;
    assign proc_gnt = (owner_q == OWN_PROC) && proc_req;
    assign disp_gnt = (owner_q == OWN_DISP) && disp_req;
    assign busy     = spi_gnt || proc_gnt || disp_gnt;

`ifdef ARB_AGING_EN
    dcache_arb_age #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_age (
        .clk           (clk),
        .rst           (rst),
        .disp_req      (disp_req),
        .disp_gnt      (disp_gnt),
        .starve_force_c(age_force_c)
    );
`else
    assign age_force_c = 1'b0;
`endif

    // Owner state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Next owner: SPI burst lock, then starvation override, then fixed priority.
    always_comb begin
        owner_d = OWN_NONE;
        if (owner_q == OWN_SPI && spi_lock) begin
            owner_d = OWN_SPI;
        end else if (age_force_c) begin
            owner_d = OWN_DISP;
        end else if (spi_req) begin
            owner_d = OWN_SPI;
        end else if (proc_req) begin
            owner_d = OWN_PROC;
        end else if (disp_req) begin
            owner_d = OWN_DISP;
        end
    end

    // Cache port mux follows the owner; the display path never writes.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        rdata     = '0;
        case (owner_q)
            OWN_SPI: begin
                mem_addr  = spi_addr;
                mem_wdata = spi_wdata;
            end
            OWN_PROC: begin
                mem_addr  = proc_addr;
                mem_wdata = proc_wdata;
            end
            OWN_DISP: begin
                mem_addr  = disp_addr;
            end
            default: begin
            end
        endcase
        mem_wen = (spi_gnt && spi_we) || (proc_gnt && proc_we);
        if (busy) begin
            rdata = mem_rdata;
        end
    end

endmodule

// File: doc/dcache_arbiter.md
DCACHE_ARBITER -- requirements
Module: dcache_arbiter

Interface
REQ-001 Parameter ADDR_W, default 4: dcache address width (16 entries).
REQ-002 Parameter DATA_W, default `DATAPATH_W (8): data width.
REQ-003 Parameter STARVE_LIMIT, default 8: display wait cycles before forced grant (range 1..15).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 spi_req / spi_we / spi_lock  in  1 each  SPI loader request, write flag, burst lock.
REQ-007 spi_addr  in  ADDR_W; spi_wdata  in  DATA_W  SPI loader access.
REQ-008 proc_req / proc_we  in  1 each; proc_addr  in  ADDR_W; proc_wdata  in  DATA_W  processor access.
REQ-009 disp_req  in  1; disp_addr  in  ADDR_W  seven-segment read-only access.
REQ-010 spi_gnt / proc_gnt / disp_gnt  out  1 each  access performed this cycle.
REQ-011 rdata  out  DATA_W  read data, meaningful only with a gnt.
REQ-012 mem_wen  out  1; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W  cache port.
REQ-013 mem_rdata  in  DATA_W  cache asynchronous read data.
REQ-014 busy  out  1  any gnt high.

Function
REQ-015 Registered owner FSM, states NONE, SPI, PROC, DISP; owner for cycle N+1 decided from requests at end of cycle N.
REQ-016 Priority: SPI > PROC > DISP, except REQ-021.
REQ-017 x_gnt = (owner==x) & x_req; a request dropped in its owner cycle yields no gnt and no write.
REQ-018 Access latency: gnt one cycle after first req sampled with no higher-priority contender; requester holds req/addr/wdata until gnt.
REQ-019 Back-to-back: req held after gnt re-arbitrates; same requester may win consecutive cycles.
REQ-020 spi_lock high in a SPI-owned cycle keeps owner SPI next cycle regardless of others; lock ignored when owner not SPI.
REQ-021 Aging: 4-bit starve counter increments each cycle disp_req high and disp_gnt low, saturating at STARVE_LIMIT; at STARVE_LIMIT DISP wins next arbitration over PROC and SPI, unless spi_lock holds SPI.
REQ-022 Starve counter clears on disp_gnt or disp_req low.
REQ-023 mem_addr/mem_wdata muxed from owner; NONE drives zero; mem_wen = spi_gnt&spi_we | proc_gnt&proc_we; DISP never writes.
REQ-024 rdata = mem_rdata in any gnt cycle, else 0.
REQ-025 No requests: owner NONE next cycle, all outputs 0.
REQ-026 At most one gnt per cycle; mem_wen never high without a gnt.

Reset
REQ-027 rst: owner NONE, starve counter 0, all gnt, mem_wen, busy, rdata, mem_addr, mem_wdata 0 in the cycle after rst sampled.
REQ-028 rst mid-burst or mid-grant aborts: no write the cycle after rst; arbitration resumes first cycle after rst deasserts.

Configuration
REQ-029 ARB_AGING_EN defined: REQ-021/022 in effect.
REQ-030 ARB_AGING_EN undefined: no starve counter, pure fixed priority; all else identical.

Structure
REQ-031 Shared package/defs header: owner-state encodings (NONE=2'b00, SPI=01, PROC=10, DISP=11) and STARVE_LIMIT default.
REQ-032 One sub-module dcache_arb_age (starve counter, force output), instantiated only under ARB_AGING_EN.

Verification
REQ-033 proc_req=1 we=1 addr=3 wdata=8'h5A alone -> proc_gnt next cycle, mem_wen=1 mem_addr=3 mem_wdata=5A, one cycle only.
REQ-034 spi_req and proc_req same cycle -> spi_gnt first, proc_gnt following cycle; never both.
REQ-035 spi_lock=1 for 4 SPI writes to addr 0..3 while proc_req=1 -> 4 consecutive spi_gnt, proc_gnt on the 5th cycle.
REQ-036 ARB_AGING_EN, STARVE_LIMIT=8, proc_req held, disp_req=1 addr=9 -> disp_gnt after counter hits 8, rdata=mem[9], counter back to 0.
REQ-037 proc_req dropped in its owner cycle -> no gnt, mem_wen=0; rst asserted during SPI lock -> all outputs 0 next cycle.
REQ-038 ARB_AGING_EN undefined, proc_req held 20 cycles with disp_req -> no disp_gnt until proc_req drops.
